// File: rtl/eth_mmio_arbiter.sv
// ============================================================================
// eth_mmio_arbiter
//
// Purpose:
//   Shares one ethernet controller register port among num_ch_p MMIO masters.
//   Requests are granted round-robin with zero issue latency. Reads are
//   tracked in a channel-ID FIFO so that the controller's in-order read
//   responses are routed back to the channel that issued them.
//
// Optional feature (compile-time macro ETH_MMIO_ARB_TIMEOUT_EN):
//   When defined, a read that waits timeout_p cycles without a response is
//   retired with a 0xDEADBEEF filler pattern, and timeout_o is set sticky.
//   When undefined, there is no timeout logic and timeout_o is tied 0.
//
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   ch_v_i / ch_write_i       per-channel request valid / write(1) read(0)
//   ch_addr_i, ch_op_size_i,
//   ch_data_i                 packed per-channel request fields (ch0 in LSBs)
//   ch_ready_o                one-hot grant (accept = v & ready)
//   ch_rdata_o, ch_rdata_v_o  shared read data, one-hot read-response valid
//   addr_o, write_en_o, read_en_o, op_size_o, write_data_o
//                             controller request port
//   read_data_i, read_data_v_i
//                             controller read response
//   err_o                     sticky: response arrived with no read in flight
//   timeout_o                 sticky: a read was retired by the timeout
// ============================================================================
module eth_mmio_arbiter #(
    parameter int num_ch_p          = 2,
    parameter int axis_width_p      = 64,
    parameter int addr_width_p      = 16,
    parameter int max_outstanding_p = 4,
    parameter int timeout_p         = 256
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_ch_p-1:0]              ch_v_i,
    input  logic [num_ch_p-1:0]              ch_write_i,
    input  logic [num_ch_p*addr_width_p-1:0] ch_addr_i,
    input  logic [num_ch_p*2-1:0]            ch_op_size_i,
    input  logic [num_ch_p*axis_width_p-1:0] ch_data_i,
    output logic [num_ch_p-1:0]              ch_ready_o,
    output logic [axis_width_p-1:0]          ch_rdata_o,
    output logic [num_ch_p-1:0]              ch_rdata_v_o,
    output logic [addr_width_p-1:0]          addr_o,
    output logic                             write_en_o,
    output logic                             read_en_o,
    output logic [1:0]                       op_size_o,
    output logic [axis_width_p-1:0]          write_data_o,
    input  logic [axis_width_p-1:0]          read_data_i,
    input  logic                             read_data_v_i,
    output logic                             err_o,
    output logic                             timeout_o
);

    localparam int IdW  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
    localparam int PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int CntW = $clog2(max_outstanding_p) + 1;

    // Reject configurations the arbiter and ID FIFO are not built for.
    if (num_ch_p < 2 || max_outstanding_p < 1 || timeout_p < 1 ||
        (max_outstanding_p & (max_outstanding_p - 1)) != 0) begin : g_paramCheck
        $error("eth_mmio_arbiter: unsupported parameter set");
    end

    logic [addr_width_p-1:0] w_chAddr   [num_ch_p];
    logic [1:0]              w_chOpSize [num_ch_p];
    logic [axis_width_p-1:0] w_chData   [num_ch_p];

    logic [IdW-1:0]  r_rrPtr;
    logic [IdW-1:0]  r_idFifo [max_outstanding_p];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;
    logic [CntW-1:0] r_count;
    logic            r_err;

    logic            w_notEmpty;
    logic            w_realPop;
    logic            w_forcePop;
    logic            w_pop;
    logic            w_full;
    logic            w_grant;
    logic [IdW-1:0]  w_winner;
    logic [IdW-1:0]  w_idx;
    logic            w_push;
    logic [IdW-1:0]  w_head;

    // Split the packed request buses into per-channel arrays.
    for (genvar c = 0; c < num_ch_p; c++) begin : g_unpack
        assign w_chAddr[c]   = ch_addr_i[c*addr_width_p +: addr_width_p];
        assign w_chOpSize[c] = ch_op_size_i[c*2 +: 2];
        assign w_chData[c]   = ch_data_i[c*axis_width_p +: axis_width_p];
    end

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        if (p == PtrW'(max_outstanding_p - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    assign w_notEmpty = (r_count != '0);
    assign w_head     = r_idFifo[r_rdPtr];
    assign w_realPop  = reset_n_i && read_data_v_i && w_notEmpty;
    assign w_pop      = w_realPop || w_forcePop;
    // A response retiring in this same cycle frees its slot immediately.
    assign w_full     = (r_count == CntW'(max_outstanding_p)) && !w_pop;

`ifdef ETH_MMIO_ARB_TIMEOUT_EN
    localparam int ToW = $clog2(timeout_p + 1);
    localparam logic [axis_width_p-1:0] DeadFill = {(axis_width_p/32){32'hDEAD_BEEF}};

    logic [ToW-1:0] r_toCnt;
    logic           r_timeout;

    // The counter reads timeout_p-1 in the timeout_p-th cycle after the head
    // read issued; a real response in that cycle takes precedence.
    assign w_forcePop = reset_n_i && w_notEmpty && !read_data_v_i &&
                        (r_toCnt == ToW'(timeout_p - 1));
    assign timeout_o  = r_timeout;
    assign ch_rdata_o = w_forcePop ? DeadFill : read_data_i;

    // Wait counter for the FIFO head: restarts on every retirement and
    // idles at zero while nothing is in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_toCnt   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_pop || !w_notEmpty) r_toCnt <= '0;
            else                      r_toCnt <= r_toCnt + ToW'(1);
            if (w_forcePop) r_timeout <= 1'b1;
        end
    end
`else
    assign w_forcePop = 1'b0;
    assign timeout_o  = 1'b0;
    assign ch_rdata_o = read_data_i;
`endif

    // Round-robin search starting at the pointer. Reads are skipped while the
    // ID FIFO is full so that a blocked read never stalls another channel.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < num_ch_p; k++) begin
            w_idx = IdW'((int'(r_rrPtr) + k) % num_ch_p);
            if (reset_n_i && !w_grant && ch_v_i[w_idx] &&
                (ch_write_i[w_idx] || !w_full)) begin
                w_grant  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_push       = w_grant && !ch_write_i[w_winner];
    assign ch_ready_o   = w_grant ? (num_ch_p'(1) << w_winner) : '0;
    assign write_en_o   = w_grant && ch_write_i[w_winner];
    assign read_en_o    = w_push;
    assign addr_o       = w_grant ? w_chAddr[w_winner]   : '0;
    assign op_size_o    = w_grant ? w_chOpSize[w_winner] : '0;
    assign write_data_o = w_grant ? w_chData[w_winner]   : '0;
    assign ch_rdata_v_o = w_pop ? (num_ch_p'(1) << w_head) : '0;
    assign err_o        = r_err;

    // ID FIFO storage; only the pointers and count need a reset.
    always_ff @(posedge clk_i) begin
        if (w_push) r_idFifo[r_wrPtr] <= w_winner;
    end

    // Arbitration pointer, FIFO bookkeeping and the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rrPtr <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rrPtr <= (w_winner == IdW'(num_ch_p - 1)) ? '0 : w_winner + IdW'(1);
            end
            if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
            if (read_data_v_i && !w_notEmpty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_mmio_arbiter.sv
// ============================================================================
// tb_eth_mmio_arbiter
//
// Purpose:
//   Self-checking bench for eth_mmio_arbiter in its default build
//   (ETH_MMIO_ARB_TIMEOUT_EN undefined). A queue-based reference model
//   predicts every output each cycle; directed sequences add fixed
//   expectations for the key scenarios, followed by a randomized phase.
// ============================================================================
module tb_eth_mmio_arbiter;

    localparam int NCh    = 2;
    localparam int DW     = 64;
    localparam int AW     = 16;
    localparam int MaxOut = 4;

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic [NCh-1:0]      ch_v_i;
    logic [NCh-1:0]      ch_write_i;
    logic [NCh*AW-1:0]   ch_addr_i;
    logic [NCh*2-1:0]    ch_op_size_i;
    logic [NCh*DW-1:0]   ch_data_i;
    logic [NCh-1:0]      ch_ready_o;
    logic [DW-1:0]       ch_rdata_o;
    logic [NCh-1:0]      ch_rdata_v_o;
    logic [AW-1:0]       addr_o;
    logic                write_en_o;
    logic                read_en_o;
    logic [1:0]          op_size_o;
    logic [DW-1:0]       write_data_o;
    logic [DW-1:0]       read_data_i;
    logic                read_data_v_i;
    logic                err_o;
    logic                timeout_o;

    eth_mmio_arbiter #(
        .num_ch_p(NCh), .axis_width_p(DW), .addr_width_p(AW),
        .max_outstanding_p(MaxOut), .timeout_p(256)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .ch_v_i(ch_v_i), .ch_write_i(ch_write_i), .ch_addr_i(ch_addr_i),
        .ch_op_size_i(ch_op_size_i), .ch_data_i(ch_data_i),
        .ch_ready_o(ch_ready_o), .ch_rdata_o(ch_rdata_o), .ch_rdata_v_o(ch_rdata_v_o),
        .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
        .op_size_o(op_size_o), .write_data_o(write_data_o),
        .read_data_i(read_data_i), .read_data_v_i(read_data_v_i),
        .err_o(err_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state: in-order queue of issuing channels for reads.
    int modelQ[$];
    int modelRr  = 0;
    bit modelErr = 1'b0;

    // Per-cycle predictions, consumed again when the clock edge commits them.
    int expWinner;
    bit expPop;
    bit expErrSet;

    bit prevRead;
    logic [AW-1:0] prevAddr;
    logic [DW-1:0] rspData;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Predict this cycle's outputs from the queue model and compare all of them.
    task automatic evalModel();
        bit full;
        int c;
        logic [NCh-1:0] expReady;
        logic [NCh-1:0] expRv;
        expWinner = -1;
        expPop    = 1'b0;
        expErrSet = 1'b0;
        checkOutput("timeout", timeout_o, 0);
        if (!reset_n_i) begin
            checkOutput("rstReady", ch_ready_o, 0);
            checkOutput("rstWe", write_en_o, 0);
            checkOutput("rstRe", read_en_o, 0);
            checkOutput("rstRv", ch_rdata_v_o, 0);
            checkOutput("rstAddr", addr_o, 0);
            checkOutput("rstOp", op_size_o, 0);
            checkOutput("rstWd", write_data_o, 0);
        end else begin
            expPop    = read_data_v_i && (modelQ.size() > 0);
            expErrSet = read_data_v_i && (modelQ.size() == 0);
            full      = (modelQ.size() - int'(expPop)) >= MaxOut;
            for (int k = 0; k < NCh; k++) begin
                c = (modelRr + k) % NCh;
                if (expWinner < 0 && ch_v_i[c] && (ch_write_i[c] || !full)) expWinner = c;
            end
            expReady = (expWinner >= 0) ? (NCh'(1) << expWinner) : '0;
            expRv    = expPop ? (NCh'(1) << modelQ[0]) : '0;
            checkOutput("ready", ch_ready_o, expReady);
            checkOutput("rdataV", ch_rdata_v_o, expRv);
            checkOutput("err", err_o, modelErr);
            if (expWinner >= 0) begin
                checkOutput("we", write_en_o, ch_write_i[expWinner]);
                checkOutput("re", read_en_o, !ch_write_i[expWinner]);
                checkOutput("addr", addr_o, ch_addr_i[expWinner*AW +: AW]);
                checkOutput("opSize", op_size_o, ch_op_size_i[expWinner*2 +: 2]);
                checkOutput("wdata", write_data_o, ch_data_i[expWinner*DW +: DW]);
            end else begin
                checkOutput("weIdle", write_en_o, 0);
                checkOutput("reIdle", read_en_o, 0);
            end
            if (expPop) checkOutput("rdata", ch_rdata_o, read_data_i);
        end
    endtask

    // Drive one cycle of inputs, then sample and check on the falling edge.
    task automatic applyStimulus(input bit rstN, input logic [1:0] v, input logic [1:0] wr,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input bit rdv, input logic [DW-1:0] rd);
        reset_n_i     = rstN;
        ch_v_i        = v;
        ch_write_i    = wr;
        ch_addr_i     = {a1, a0};
        ch_op_size_i  = 4'($urandom);
        ch_data_i     = {d1, d0};
        read_data_v_i = rdv;
        read_data_i   = rd;
        @(negedge clk_i);
        evalModel();
    endtask

    // Commit the cycle's predictions into the model at the rising edge.
    task automatic stepClock();
        @(posedge clk_i);
        if (!reset_n_i) begin
            modelQ.delete();
            modelRr  = 0;
            modelErr = 1'b0;
        end else begin
            if (expPop) void'(modelQ.pop_front());
            if (expWinner >= 0) begin
                if (!ch_write_i[expWinner]) modelQ.push_back(expWinner);
                modelRr = (expWinner + 1) % NCh;
            end
            if (expErrSet) modelErr = 1'b1;
        end
        #1;
    endtask

    task automatic idleCycle(input bit rstN);
        applyStimulus(rstN, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        @(posedge clk_i);
        #1;

        // Reset with requests pending: nothing may be granted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b01, 16'h1, 16'h2, 64'h3, 64'h4, 1'b1, 64'h5);
            stepClock();
        end

        // Single ch0 write.
        applyStimulus(1'b1, 2'b01, 2'b01, 16'h0010, 16'h0, 64'h1122334455667788, 64'h0, 1'b0, '0);
        checkOutput("wrReady", ch_ready_o, 2'b01);
        checkOutput("wrEn", write_en_o, 1);
        checkOutput("wrAddr", addr_o, 16'h0010);
        checkOutput("wrData", write_data_o, 64'h1122334455667788);
        checkOutput("wrNoRv", ch_rdata_v_o, 2'b00);
        checkOutput("rstErr", err_o, 0);
        stepClock();
        // Pointer moved to ch1.
        applyStimulus(1'b1, 2'b11, 2'b11, 16'h20, 16'h30, 64'h1, 64'h2, 1'b0, '0);
        checkOutput("ptrAdv", ch_ready_o, 2'b10);
        stepClock();

        // Both channels read every cycle; controller echoes the address next cycle.
        idleCycle(1'b0);
        stepClock();
        prevRead = 1'b0;
        prevAddr = '0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'b11, 2'b00, AW'(16'h100 + 2*i), AW'(16'h101 + 2*i),
                          '0, '0, prevRead, DW'(prevAddr));
            checkOutput("altGrant", ch_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                checkOutput("altRspCh", ch_rdata_v_o, (i % 2 == 1) ? 2'b01 : 2'b10);
                checkOutput("altRspData", ch_rdata_o, DW'(AW'(16'h100 + 2*(i-1) + ((i-1) % 2))));
            end
            prevRead = (expWinner >= 0) && !ch_write_i[expWinner];
            prevAddr = (expWinner >= 0) ? ch_addr_i[expWinner*AW +: AW] : '0;
            stepClock();
        end

        // Fill the outstanding limit with ch0 reads.
        idleCycle(1'b0);
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b01, 2'b00, AW'(16'h40 + i), '0, '0, '0, 1'b0, '0);
            checkOutput("fillReady", ch_ready_o, 2'b01);
            stepClock();
        end
        applyStimulus(1'b1, 2'b01, 2'b00, 16'h44, '0, '0, '0, 1'b0, '0);
        checkOutput("fullBlock", ch_ready_o, 2'b00);
        checkOutput("fullNoRe", read_en_o, 0);
        stepClock();
        applyStimulus(1'b1, 2'b11, 2'b10, 16'h44, 16'h50, '0, 64'hAA, 1'b0, '0);
        checkOutput("fullWrPass", ch_ready_o, 2'b10);
        checkOutput("fullWrEn", write_en_o, 1);
        stepClock();
        applyStimulus(1'b1, 2'b01, 2'b00, 16'h44, '0, '0, '0, 1'b1, 64'hCAFE);
        checkOutput("popFrees", ch_ready_o, 2'b01);
        checkOutput("popRe", read_en_o, 1);
        checkOutput("popRv", ch_rdata_v_o, 2'b01);
        checkOutput("popData", ch_rdata_o, 64'hCAFE);
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1, DW'(i));
            checkOutput("drainRv", ch_rdata_v_o, 2'b01);
            stepClock();
        end

        // Response with nothing outstanding.
        applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 64'hBAD);
        checkOutput("emptyRv", ch_rdata_v_o, 2'b00);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b1);
            checkOutput("errSticky", err_o, 1);
            stepClock();
        end
        idleCycle(1'b0);
        stepClock();
        idleCycle(1'b1);
        checkOutput("errCleared", err_o, 0);
        stepClock();

        // Reset with two reads in flight, then stale responses.
        applyStimulus(1'b1, 2'b11, 2'b00, 16'h60, 16'h61, '0, '0, 1'b0, '0);
        stepClock();
        applyStimulus(1'b1, 2'b11, 2'b00, 16'h62, 16'h63, '0, '0, 1'b0, '0);
        stepClock();
        idleCycle(1'b0);
        stepClock();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 64'h77);
            checkOutput("staleRv", ch_rdata_v_o, 2'b00);
            stepClock();
        end
        idleCycle(1'b1);
        checkOutput("staleErr", err_o, 1);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b01, 2'b00, AW'(16'h70 + i), '0, '0, '0, 1'b0, '0);
            checkOutput("postRstCnt", ch_ready_o, (i < 4) ? 2'b01 : 2'b00);
            stepClock();
        end

        // Randomized traffic with occasional resets and stray responses.
        idleCycle(1'b0);
        stepClock();
        for (int i = 0; i < 600; i++) begin
            rspData = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 99) != 0, 2'($urandom), 2'($urandom),
                          AW'($urandom), AW'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          (modelQ.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 29) == 0),
                          rspData);
            stepClock();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
